// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern scan controller: config register, history shift, match/limit/timeout FSM.
// Latency: match on the bit sampled at edge M shows on seq_seen/match_count in the cycle after M.
// Backpressure: cfg_ready is high only in IDLE; held config offers wait there, bits outside SCAN are dropped.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_limit,
  input  logic               cfg_overlap,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               inp_bit,
  output logic               seq_seen,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               timed_out
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  state_t state, state_nxt;

  // Stored configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   limit_r;
  logic               overlap_r;
  logic [TO_W-1:0]    timeout_r;

  // Scan state
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [TO_W-1:0]    timer;

  // Combinational helpers
  logic [MAX_LEN-1:0] hist_new;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   len_clamped;
  logic [CNT_W-1:0]   count_inc;
  logic [TO_W-1:0]    timer_inc;
  logic               scan_bit;
  logic               is_match;
  logic               limit_hit;
  logic               to_hit;
  logic               cfg_take;
  logic               start_take;

  // Match detection, saturating increments and config length clamping
  always_comb begin
    hist_new = {hist[MAX_LEN-2:0], inp_bit};
    fill_inc = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_r));
    end
    // An abort in the same cycle discards the bit entirely.
    scan_bit  = (state == S_SCAN) && bit_valid && !abort;
    is_match  = scan_bit && (fill_inc >= len_r) && ((hist_new & mask) == (pat_r & mask));
    count_inc = (&match_count) ? match_count : match_count + CNT_W'(1);
    limit_hit = (limit_r != '0) && (count_inc == limit_r);
    timer_inc = timer + TO_W'(1);
    to_hit    = (timeout_r != '0) && (timer_inc == timeout_r);
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end else begin
      len_clamped = cfg_len;
    end
  end

  // Next-state and state-decoded outputs; abort beats match, match beats timeout
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cfg_take   = 1'b0;
    start_take = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        cfg_take  = cfg_valid;
        if (start) begin
          start_take = 1'b1;
          state_nxt  = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (is_match) begin
          if (limit_hit) state_nxt = S_DONE;
        end else if (to_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Config register, history/fill, counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r       <= MAX_LEN'(4'b1011);
      len_r       <= LEN_W'(4);
      limit_r     <= CNT_W'(1);
      overlap_r   <= 1'b1;
      timeout_r   <= '0;
      hist        <= '0;
      fill        <= '0;
      timer       <= '0;
      match_count <= '0;
      seq_seen    <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      seq_seen <= is_match;
      if (cfg_take) begin
        pat_r     <= cfg_pattern;
        len_r     <= len_clamped;
        limit_r   <= cfg_limit;
        overlap_r <= cfg_overlap;
        timeout_r <= cfg_timeout;
      end
      if (start_take) begin
        hist        <= '0;
        fill        <= '0;
        timer       <= '0;
        match_count <= '0;
        timed_out   <= 1'b0;
      end else if (state == S_SCAN && !abort) begin
        if (bit_valid) begin
          hist <= hist_new;
          // Non-overlapping mode restarts the fill so no bit is reused.
          fill <= (is_match && !overlap_r) ? '0 : fill_inc;
        end
        if (is_match) begin
          match_count <= count_inc;
          timer       <= '0;
        end else begin
          timer <= timer_inc;
          if (to_hit) timed_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: table of whole-scan vectors plus hand sequences for timing corners.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Every wait on the DUT is bounded by a fixed cycle budget.
module tb_seq_detect_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_limit;
  logic        cfg_overlap;
  logic [15:0] cfg_timeout;
  logic        start;
  logic        abort;
  logic        bit_valid;
  logic        inp_bit;
  logic        seq_seen;
  logic [7:0]  match_count;
  logic        busy;
  logic        done;
  logic        timed_out;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_cnt = 0;
  int done_cnt = 0;

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TO_W(16)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_limit(cfg_limit),
    .cfg_overlap(cfg_overlap), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .bit_valid(bit_valid), .inp_bit(inp_bit),
    .seq_seen(seq_seen), .match_count(match_count), .busy(busy),
    .done(done), .timed_out(timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pat;
    logic [3:0]  len;
    logic [7:0]  limit;
    logic        ov;
    logic [15:0] tmo;
    logic [15:0] bits;      // first bit sent is bits[nbits-1]
    int          nbits;
    logic        gap;       // idle cycle after every bit
    logic        abort_end; // scan never ends by itself: abort it
    logic [7:0]  exp_cnt;
    int          exp_seen;
    int          exp_done;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stick();
    tick();
    seen_cnt += int'(seq_seen);
    done_cnt += int'(done);
  endtask

  task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] lim,
                         input logic ov, input logic [15:0] tmo);
    cfg_pattern = p; cfg_len = l; cfg_limit = lim; cfg_overlap = ov; cfg_timeout = tmo;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    set_cfg(v.pat, v.len, v.limit, v.ov, v.tmo);
    cfg_valid = 1'b1;
    start     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    start     = 1'b0;
    seen_cnt  = 0;
    done_cnt  = 0;
    check($sformatf("v%0d_busy", idx), busy, 1);
    for (int i = v.nbits - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      inp_bit   = v.bits[i];
      stick();
      bit_valid = 1'b0;
      inp_bit   = 1'b0;
      if (v.gap) stick();
    end
    if (v.abort_end) begin
      stick();
      abort = 1'b1;
      stick();
      abort = 1'b0;
    end else begin
      n = 0;
      while (busy && n < 40) begin
        stick();
        n++;
      end
    end
    check($sformatf("v%0d_ended", idx), busy, 0);
    stick();
    check($sformatf("v%0d_count", idx), match_count, v.exp_cnt);
    check($sformatf("v%0d_seen", idx), seen_cnt, v.exp_seen);
    check($sformatf("v%0d_done", idx), done_cnt, v.exp_done);
    check($sformatf("v%0d_timed_out", idx), timed_out, v.exp_to);
    check($sformatf("v%0d_ready", idx), cfg_ready, 1);
  endtask

  initial begin
    //          pat    len  limit ov tmo    bits             n  gap ab  cnt seen done to
    vecs[0] = '{8'h05, 4'd3,  8'd0, 1'b1, 16'd0, 16'b10101,    5, 1'b0, 1'b1, 8'd2, 2, 0, 1'b0};
    vecs[1] = '{8'h05, 4'd3,  8'd0, 1'b0, 16'd0, 16'b10101,    5, 1'b0, 1'b1, 8'd1, 1, 0, 1'b0};
    vecs[2] = '{8'h03, 4'd2,  8'd3, 1'b1, 16'd0, 16'b111111,   6, 1'b1, 1'b0, 8'd3, 3, 1, 1'b0};
    vecs[3] = '{8'h05, 4'd3,  8'd1, 1'b1, 16'd5, 16'b000,      3, 1'b0, 1'b0, 8'd0, 0, 1, 1'b1};
    vecs[4] = '{8'hA5, 4'd12, 8'd1, 1'b1, 16'd0, 16'b10100101, 8, 1'b0, 1'b0, 8'd1, 1, 1, 1'b0};
    vecs[5] = '{8'h01, 4'd0,  8'd0, 1'b1, 16'd0, 16'b0110,     4, 1'b0, 1'b1, 8'd2, 2, 0, 1'b0};
    vecs[6] = '{8'h03, 4'd2,  8'd0, 1'b0, 16'd0, 16'b11111,    5, 1'b0, 1'b1, 8'd2, 2, 0, 1'b0};

    reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; inp_bit = 1'b0;
    set_cfg(8'h00, 4'd0, 8'd0, 1'b0, 16'd0);
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_seq_seen", seq_seen, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    check("rst_timed_out", timed_out, 0);

    // Default config 1011, limit 1: match, done and seq_seen coincide
    start = 1'b1;
    tick();
    start = 1'b0;
    check("dflt_busy", busy, 1);
    check("dflt_ready_scan", cfg_ready, 0);
    bit_valid = 1'b1;
    inp_bit = 1'b1; tick(); check("dflt_b1_seen", seq_seen, 0);
    inp_bit = 1'b0; tick(); check("dflt_b2_seen", seq_seen, 0);
    inp_bit = 1'b1; tick(); check("dflt_b3_seen", seq_seen, 0);
    inp_bit = 1'b1; tick();
    bit_valid = 1'b0;
    check("dflt_seen", seq_seen, 1);
    check("dflt_done", done, 1);
    check("dflt_busy_end", busy, 0);
    check("dflt_count", match_count, 1);
    check("dflt_ready_done", cfg_ready, 0);
    tick();
    check("dflt_ready_idle", cfg_ready, 1);
    check("dflt_seen_low", seq_seen, 0);
    check("dflt_done_low", done, 0);

    for (int v = 0; v < 7; v++) run_vec(v, vecs[v]);

    // Timeout 5 with no bits: done exactly on the 5th SCAN cycle
    set_cfg(8'h03, 4'd2, 8'd1, 1'b1, 16'd5);
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("to_c%0d_busy", k), busy, 1);
      check($sformatf("to_c%0d_done", k), done, 0);
    end
    tick();
    check("to_done", done, 1);
    check("to_busy", busy, 0);
    check("to_flag", timed_out, 1);
    check("to_count", match_count, 0);
    tick();
    check("to_ready", cfg_ready, 1);
    check("to_sticky", timed_out, 1);

    // Match landing on the 5th cycle wins over the timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tom_flag_clr", timed_out, 0);
    tick(); tick(); tick();
    bit_valid = 1'b1; inp_bit = 1'b1;
    tick();
    check("tom_c4_seen", seq_seen, 0);
    check("tom_c4_busy", busy, 1);
    tick();
    bit_valid = 1'b0; inp_bit = 1'b0;
    check("tom_seen", seq_seen, 1);
    check("tom_done", done, 1);
    check("tom_flag", timed_out, 0);
    check("tom_count", match_count, 1);
    tick();

    // Abort on the cycle of a completing match bit
    set_cfg(8'h03, 4'd2, 8'd0, 1'b1, 16'd0);
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    bit_valid = 1'b1;
    inp_bit = 1'b1; tick();
    inp_bit = 1'b1; tick();
    check("ab_first_seen", seq_seen, 1);
    check("ab_first_count", match_count, 1);
    inp_bit = 1'b0; tick();
    inp_bit = 1'b1; tick();
    check("ab_pre_seen", seq_seen, 0);
    inp_bit = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; bit_valid = 1'b0; inp_bit = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_seen", seq_seen, 0);
    check("ab_done", done, 0);
    check("ab_count", match_count, 1);
    check("ab_ready", cfg_ready, 1);
    tick();
    check("ab_done_after", done, 0);
    check("ab_count_after", match_count, 1);

    // Config offer held through a scan is taken on the first IDLE cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(8'h01, 4'd1, 8'd1, 1'b1, 16'd0);
    cfg_valid = 1'b1;
    tick();
    check("hold_ready_scan", cfg_ready, 0);
    check("hold_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hold_ready_idle", cfg_ready, 1);
    check("hold_busy_idle", busy, 0);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1; inp_bit = 1'b1;
    tick();
    bit_valid = 1'b0; inp_bit = 1'b0;
    check("hold_new_seen", seq_seen, 1);
    check("hold_new_done", done, 1);
    check("hold_new_count", match_count, 1);
    tick();

    // Reset mid-scan restores outputs and the default config
    set_cfg(8'h01, 4'd1, 8'd0, 1'b1, 16'd0);
    cfg_valid = 1'b1; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    bit_valid = 1'b1; inp_bit = 1'b1;
    tick();
    bit_valid = 1'b0;
    check("mrst_pre_count", match_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_ready", cfg_ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_seen", seq_seen, 0);
    check("mrst_done", done, 0);
    check("mrst_count", match_count, 0);
    check("mrst_timed_out", timed_out, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    inp_bit = 1'b1; tick(); check("mrst_b1_seen", seq_seen, 0);
    inp_bit = 1'b0; tick();
    inp_bit = 1'b1; tick();
    inp_bit = 1'b1; tick();
    bit_valid = 1'b0; inp_bit = 1'b0;
    check("mrst_dflt_seen", seq_seen, 1);
    check("mrst_dflt_done", done, 1);
    check("mrst_dflt_count", match_count, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern scan controller for the sequence-detection block family. It holds a run-time pattern configuration, arms a scan on `start` and shifts qualified serial bits into a history register. It counts pattern matches, in overlapping or non-overlapping mode, and ends the scan on a match limit, an idle timeout or an abort. It sits between the host/config logic and the serial bit source, and replaces hard-wired per-pattern detectors.

## Interface
Parameters:
- `MAX_LEN`, 8: maximum pattern length in bits.
- `CNT_W`, 8: width of the match counter and of the limit.
- `TO_W`, 16: width of the timeout counter.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config accepted when `cfg_valid` and `cfg_ready` are both high.
- `cfg_pattern` in MAX_LEN: pattern; bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len` in $clog2(MAX_LEN+1): pattern length.
- `cfg_limit` in CNT_W: matches that end the scan; 0 means unlimited.
- `cfg_overlap` in 1: 1 allows overlapping matches.
- `cfg_timeout` in TO_W: consecutive no-match SCAN cycles before timeout; 0 disables the timeout.
- `start` in 1: begin a scan (honoured in IDLE only).
- `abort` in 1: cancel the scan.
- `bit_valid` in 1: qualifies `inp_bit`.
- `inp_bit` in 1: serial data bit.
- `seq_seen` out 1: one-cycle pulse per match.
- `match_count` out CNT_W: matches in the current or last scan.
- `busy` out 1: high in SCAN.
- `done` out 1: one-cycle pulse on normal scan end.
- `timed_out` out 1: sticky; set when a scan ends by timeout, cleared on the next `start`.

## Operation
- **States:** IDLE, SCAN, DONE.
  - IDLE → SCAN on `start`.
  - SCAN → DONE on limit reached or timeout.
  - SCAN → IDLE on `abort`.
  - DONE → IDLE unconditionally after one cycle.
- **Config register**
  - Written only in IDLE: `cfg_ready` = 1 in IDLE, 0 otherwise.
  - Held offers wait until the controller returns to IDLE.
  - Reset value: pattern 4'b1011, len 4, limit 1, overlap 1, timeout 0.
  - Length clamping: `cfg_len` 0 is stored as 1; `cfg_len` > MAX_LEN is stored as MAX_LEN.
  - `start` in the same cycle as a config accept scans with the incoming config.
- **Start:** clears the history register, fill count, `match_count`, the timeout timer and `timed_out`.
- **Scan (per `bit_valid` cycle in SCAN)**
  - Shift `inp_bit` into history LSB.
  - Fill count increments, saturating at MAX_LEN.
- **Match condition:** `bit_valid`, fill ≥ len, and the new history[len-1:0] equals pattern[len-1:0].
- **On a match**
  - `match_count` increments, saturating at all-ones.
  - Timer clears.
  - If overlap = 0, fill count resets to 0, so no bit is reused.
- **Limit:** when limit ≠ 0 and the incremented count equals limit, the next state is DONE.
- **Timeout:** each SCAN cycle without a match increments the timer. If timeout ≠ 0 and timer+1 equals timeout, the next state is DONE and `timed_out` is set.
- **Priority (highest first):** reset > abort > match/limit > timeout.
  - A match in the timeout cycle counts and prevents the timeout.
  - Abort discards the current bit; no `done` pulse, and `match_count` holds.
- **Ignored inputs:** `start` outside IDLE, `abort` outside SCAN, and `bit_valid` outside SCAN.

## Timing
- **Reset values:** `cfg_ready` = 1, `busy` = 0, `seq_seen` = 0, `done` = 0, `match_count` = 0, `timed_out` = 0; state IDLE.
- **Start latency:** `start` sampled at edge N gives `busy` = 1 from N to the end of the scan. A bit with `bit_valid` in the cycle after edge N is the first bit scanned.
- **Match latency:** a bit sampled at edge M makes `seq_seen` = 1 and updates `match_count` in the cycle after M; both are registered, one cycle of latency.
- **Scan end**
  - The terminating edge (limit or timeout) moves the controller to DONE: `busy` = 0 and `done` = 1 for that one cycle.
  - On a limit end, `seq_seen` is high in the same cycle as `done`.
  - `cfg_ready` returns to 1 in the following cycle (IDLE).
- **Timeout cycle count:** timeout T fires after exactly T consecutive no-match SCAN cycles.
- **Back-to-back bits:** `bit_valid` may be high every cycle; there are no bubbles.
- **Reset mid-scan:** the next cycle is IDLE with all outputs at reset values and the default config restored.

## Test plan
- Default config (no cfg write), `start`, then stream 1,0,1,1 with `bit_valid` every cycle → one `seq_seen` pulse the cycle after the 4th bit, `match_count` = 1, `done` in the same cycle, IDLE next.
- Config 101, len 3, limit 0, overlap 1; stream 1,0,1,0,1 → 2 matches; same with overlap 0 → 1 match.
- Config 11, limit 3, timeout 0; stream 1,1,1,1,1,1 with `bit_valid` gapped every other cycle → matches after bits 2, 3 and 4 (overlap 1), `done` with the 3rd, later bits ignored.
- Timeout 5, stream of zeros → `done` after exactly 5 SCAN cycles, `timed_out` = 1, `match_count` = 0. A match landing on the 5th cycle → no timeout, count = 1.
- `abort` on the same cycle as a completing match bit → IDLE, no `seq_seen`, no `done`, `match_count` unchanged. Reset mid-scan → all outputs at reset values next cycle.
- `cfg_valid` held during SCAN → `cfg_ready` = 0 and the offer is accepted on the first IDLE cycle. `cfg_len` = 0 is stored as 1; `cfg_len` = 12 is stored as 8.
